bht_branch_predictor: RTL and testbench

Parametrised branch predictor replacing the single-FSM predictor in the 5-stage RV32I pipeline. It holds a table of ENTRIES saturating counters, indexed by PC or by gshare (PC XOR global history). The decode stage receives a combinational taken/not-taken prediction and branch target. The MEM stage trains the table with resolved outcomes. Built-in statistics counters record resolved branches and mispredicts for the cycle-counter/morse readout path.

---
 rtl/bht_branch_predictor_pkg.sv | 19 +
 rtl/bht_branch_predictor_sat_counter_update.sv | 23 ++
 rtl/bht_branch_predictor.sv | 138 +++++++++++++
 tb/tb_bht_branch_predictor.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bht_branch_predictor_pkg.sv
// Shared definitions for the branch history table predictor.
package bht_branch_predictor_pkg;

  localparam int unsigned DEF_ENTRIES = 64;
  localparam int unsigned DEF_CTR_W   = 2;
  localparam int unsigned DEF_GHR_W   = 0;
  localparam int unsigned DEF_STAT_W  = 16;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Weakly-not-taken value for a ctr_w-bit counter (0 for a 1-bit counter).
  function automatic int unsigned weak_not_taken(input int unsigned ctr_w);
    return (32'd1 << (ctr_w - 32'd1)) - 32'd1;
  endfunction

endpackage

// File: rtl/bht_branch_predictor_sat_counter_update.sv
// Next-value logic for a W-bit saturating up/down counter.
module bht_branch_predictor_sat_counter_update #(
  parameter int unsigned W = 2
) (
  input  logic [W-1:0] value,
  input  logic         en,
  input  logic         up,
  output logic [W-1:0] next_c
);

  // Step toward all-ones or zero, holding at either rail.
  always_comb begin
    next_c = value;
    if (en) begin
      if (up) begin
        if (value != {W{1'b1}}) next_c = value + W'(1);
      end else begin
        if (value != '0) next_c = value - W'(1);
      end
    end
  end

endmodule

// File: rtl/bht_branch_predictor.sv
// Bimodal / gshare branch predictor with table init sequencer and statistics.
module bht_branch_predictor
  import bht_branch_predictor_pkg::*;
#(
  parameter  int unsigned ENTRIES = DEF_ENTRIES,
  parameter  int unsigned CTR_W   = DEF_CTR_W,
  parameter  int unsigned GHR_W   = DEF_GHR_W,
  parameter  int unsigned STAT_W  = DEF_STAT_W,
  localparam int unsigned IDX_W   = $clog2(ENTRIES)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              lookup_valid_i,
  input  logic [31:0]       lookup_pc_i,
  input  logic [31:0]       lookup_offset_i,
  output logic              predict_o,
  output logic [31:0]       target_o,
  output logic [IDX_W-1:0]  lookup_idx_o,
  input  logic              update_valid_i,
  input  logic [IDX_W-1:0]  update_idx_i,
  input  logic              update_taken_i,
  input  logic              update_mispredict_i,
  output logic              ready_o,
  output logic [STAT_W-1:0] stat_branches_o,
  output logic [STAT_W-1:0] stat_mispredicts_o
);

  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(weak_not_taken(CTR_W));
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   init_ptr_q;
  logic [CTR_W-1:0]   table_q [ENTRIES];
  logic [STAT_W-1:0]  branches_q, mispredicts_q;
  logic [STAT_W-1:0]  branches_next_c, mispredicts_next_c;
  logic [CTR_W-1:0]   upd_cur_c, upd_next_c;
  logic               wr_en_c;
  logic [IDX_W-1:0]   wr_addr_c;
  logic [CTR_W-1:0]   wr_data_c;
  logic               upd_run_c;
  logic               unused_pc_c;

  assign upd_run_c   = (state_q == ST_RUN) && update_valid_i;
  assign unused_pc_c = ^{lookup_pc_i[31:IDX_W+2], lookup_pc_i[1:0]};

  // Table index: plain PC bits, or PC bits folded with resolved-branch history.
  if (GHR_W == 0) begin : g_bimodal
    assign lookup_idx_o = lookup_pc_i[IDX_W+1:2];
  end else begin : g_gshare
    logic [GHR_W-1:0] ghr_q;

    // History shifts in the outcome of each resolved branch.
    always_ff @(posedge clk_i) begin
      if (rst_i) ghr_q <= '0;
      else if (upd_run_c) ghr_q <= GHR_W'({ghr_q, update_taken_i});
    end

    assign lookup_idx_o = lookup_pc_i[IDX_W+1:2] ^ IDX_W'(ghr_q);
  end

  // Zero-latency lookup; reads the table as it stood before this cycle's update.
  assign ready_o   = (state_q == ST_RUN);
  assign predict_o = ready_o && lookup_valid_i && table_q[lookup_idx_o][CTR_W-1];
  assign target_o  = lookup_pc_i + lookup_offset_i;

  assign upd_cur_c = table_q[update_idx_i];

  bht_branch_predictor_sat_counter_update #(.W(CTR_W)) u_ctr_upd (
    .value  (upd_cur_c),
    .en     (1'b1),
    .up     (update_taken_i),
    .next_c (upd_next_c)
  );

  bht_branch_predictor_sat_counter_update #(.W(STAT_W)) u_br_upd (
    .value  (branches_q),
    .en     (1'b1),
    .up     (1'b1),
    .next_c (branches_next_c)
  );

  bht_branch_predictor_sat_counter_update #(.W(STAT_W)) u_mp_upd (
    .value  (mispredicts_q),
    .en     (update_mispredict_i),
    .up     (1'b1),
    .next_c (mispredicts_next_c)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_INIT;
    else       state_q <= state_d;
  end

  // Next state and the single table write port (init fill or training).
  always_comb begin
    state_d   = state_q;
    wr_en_c   = 1'b0;
    wr_addr_c = update_idx_i;
    wr_data_c = upd_next_c;
    case (state_q)
      ST_INIT: begin
        wr_en_c   = 1'b1;
        wr_addr_c = init_ptr_q;
        wr_data_c = CTR_INIT;
        if (init_ptr_q == LAST_IDX) state_d = ST_RUN;
      end
      ST_RUN: wr_en_c = update_valid_i;
      default: state_d = ST_INIT;
    endcase
  end

  // Init fill pointer.
  always_ff @(posedge clk_i) begin
    if (rst_i) init_ptr_q <= '0;
    else if (state_q == ST_INIT) init_ptr_q <= init_ptr_q + IDX_W'(1);
  end

  // Counter table storage, no reset so it maps onto RAM.
  always_ff @(posedge clk_i) begin
    if (wr_en_c && !rst_i) table_q[wr_addr_c] <= wr_data_c;
  end

  // Resolved-branch and mispredict statistics.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      branches_q    <= '0;
      mispredicts_q <= '0;
    end else if (upd_run_c) begin
      branches_q    <= branches_next_c;
      mispredicts_q <= mispredicts_next_c;
    end
  end

  assign stat_branches_o    = branches_q;
  assign stat_mispredicts_o = mispredicts_q;

endmodule

// File: tb/tb_bht_branch_predictor.sv
// Bench for bht_branch_predictor: bimodal, gshare and narrow-stats instances.
module tb_bht_branch_predictor;

  localparam int unsigned IW = 6;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Bimodal instance, default parameters
  logic b_rst, b_lv, b_uv, b_ut, b_um, b_pred, b_rdy;
  logic [31:0] b_pc, b_off, b_tgt;
  logic [IW-1:0] b_uidx, b_lidx;
  logic [15:0] b_sb, b_sm;
  // Gshare instance, GHR_W = 4
  logic g_rst, g_lv, g_uv, g_ut, g_um, g_pred, g_rdy;
  logic [31:0] g_pc, g_off, g_tgt;
  logic [IW-1:0] g_uidx, g_lidx;
  logic [15:0] g_sb, g_sm;
  // Narrow statistics instance, STAT_W = 2, GHR_W = 2
  logic s_rst, s_lv, s_uv, s_ut, s_um, s_pred, s_rdy;
  logic [31:0] s_pc, s_off, s_tgt;
  logic [IW-1:0] s_uidx, s_lidx;
  logic [1:0] s_sb, s_sm;

  bht_branch_predictor u_bim (
    .clk_i(clk), .rst_i(b_rst), .lookup_valid_i(b_lv), .lookup_pc_i(b_pc),
    .lookup_offset_i(b_off), .predict_o(b_pred), .target_o(b_tgt),
    .lookup_idx_o(b_lidx), .update_valid_i(b_uv), .update_idx_i(b_uidx),
    .update_taken_i(b_ut), .update_mispredict_i(b_um), .ready_o(b_rdy),
    .stat_branches_o(b_sb), .stat_mispredicts_o(b_sm));

  bht_branch_predictor #(.GHR_W(4)) u_gsh (
    .clk_i(clk), .rst_i(g_rst), .lookup_valid_i(g_lv), .lookup_pc_i(g_pc),
    .lookup_offset_i(g_off), .predict_o(g_pred), .target_o(g_tgt),
    .lookup_idx_o(g_lidx), .update_valid_i(g_uv), .update_idx_i(g_uidx),
    .update_taken_i(g_ut), .update_mispredict_i(g_um), .ready_o(g_rdy),
    .stat_branches_o(g_sb), .stat_mispredicts_o(g_sm));

  bht_branch_predictor #(.STAT_W(2), .GHR_W(2)) u_st (
    .clk_i(clk), .rst_i(s_rst), .lookup_valid_i(s_lv), .lookup_pc_i(s_pc),
    .lookup_offset_i(s_off), .predict_o(s_pred), .target_o(s_tgt),
    .lookup_idx_o(s_lidx), .update_valid_i(s_uv), .update_idx_i(s_uidx),
    .update_taken_i(s_ut), .update_mispredict_i(s_um), .ready_o(s_rdy),
    .stat_branches_o(s_sb), .stat_mispredicts_o(s_sm));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    int   cnt;
    b_rst = 1'b1; g_rst = 1'b1; s_rst = 1'b1;
    tick(); tick();
    sb_q.push_back('{"reset_ready", 32'd0});
    sb_q.push_back('{"reset_stat_br", 32'd0});
    e = sb_q.pop_front(); n_cmp++;
    if (32'(b_rdy) !== e.val) begin n_bad++; $display("FAIL %s: actual %0h expected %0h", e.name, b_rdy, e.val); end
    e = sb_q.pop_front(); n_cmp++;
    if (32'(b_sb) !== e.val) begin n_bad++; $display("FAIL %s: actual %0h expected %0h", e.name, b_sb, e.val); end
    b_rst = 1'b0; g_rst = 1'b0; s_rst = 1'b0;
    // Lookups and updates during INIT must have no visible effect
    b_lv = 1'b1; b_pc = 32'h28; b_uv = 1'b1; b_uidx = 6'd10; b_ut = 1'b1;
    s_lv = 1'b1; s_uv = 1'b1; s_ut = 1'b1; s_um = 1'b1; s_uidx = 6'd1;
    cnt = 0;
    while (b_rdy !== 1'b1 && cnt < 200) begin
      sb_q.push_back('{$sformatf("init_predict_%0d", cnt), 32'd0});
      e = sb_q.pop_front(); n_cmp++;
      if (32'(b_pred | s_pred) !== e.val) begin n_bad++; $display("FAIL %s: actual %0h expected %0h", e.name, b_pred | s_pred, e.val); end
      cnt++;
      tick();
    end
    b_uv = 1'b0; s_uv = 1'b0; s_um = 1'b0;
    sb_q.push_back('{"init_cycles", 32'd64});
    sb_q.push_back('{"init_ready_all", 32'd3});
    sb_q.push_back('{"init_stats_ignored", 32'd0});
    e = sb_q.pop_front(); n_cmp++;
    if (32'(cnt) !== e.val) begin n_bad++; $display("FAIL %s: actual %0d expected %0d", e.name, cnt, e.val); end
    e = sb_q.pop_front(); n_cmp++;
    if (32'({g_rdy, s_rdy}) !== e.val) begin n_bad++; $display("FAIL %s: actual %0h expected %0h", e.name, {g_rdy, s_rdy}, e.val); end
    e = sb_q.pop_front(); n_cmp++;
    if (32'({s_sb, s_sm}) !== e.val) begin n_bad++; $display("FAIL %s: actual %0h expected %0h", e.name, {s_sb, s_sm}, e.val); end
    // Every entry weakly-not-taken: index matches, predict not-taken
    for (int i = 0; i < 64; i++) begin
      b_pc = 32'(i) << 2;
      #1;
      sb_q.push_back('{$sformatf("sweep_idx_%0d", i), 32'(i)});
      sb_q.push_back('{$sformatf("sweep_pred_%0d", i), 32'd0});
      e = sb_q.pop_front(); n_cmp++;
      if (32'(b_lidx) !== e.val) begin n_bad++; $display("FAIL %s: actual %0h expected %0h", e.name, b_lidx, e.val); end
      e = sb_q.pop_front(); n_cmp++;
      if (32'(b_pred) !== e.val) begin n_bad++; $display("FAIL %s: actual %0h expected %0h", e.name, b_pred, e.val); end
    end
    // Last entry was written with 01: a single taken update flips it to predict taken
    b_uv = 1'b1; b_uidx = 6'd63; b_ut = 1'b1;
    tick();
    b_uv = 1'b0; b_pc = 32'd63 << 2;
    #1;
    sb_q.push_back('{"last_entry_weak", 32'd1});
    e = sb_q.pop_front(); n_cmp++;
    if (32'(b_pred) !== e.val) begin n_bad++; $display("FAIL %s: actual %0h expected %0h", e.name, b_pred, e.val); end
  endtask

  task automatic test_bimodal();
    exp_t e;
    logic exp_pred [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic taken    [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    b_uidx = 6'd5; b_ut = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b_uv = 1'b1; tick(); b_uv = 1'b0;
    end
    b_lv = 1'b1; b_pc = 32'h14;
    #1;
    sb_q.push_back('{"bim_idx", 32'd5});
    sb_q.push_back('{"bim_taken", 32'd1});
    e = sb_q.pop_front(); n_cmp++;
    if (32'(b_lidx) !== e.val) begin n_bad++; $display("FAIL %s: actual %0h expected %0h", e.name, b_lidx, e.val); end
    e = sb_q.pop_front(); n_cmp++;
    if (32'(b_pred) !== e.val) begin n_bad++; $display("FAIL %s: actual %0h expected %0h", e.name, b_pred, e.val); end
    b_lv = 1'b0;
    #1;
    sb_q.push_back('{"bim_unqualified", 32'd0});
    e = sb_q.pop_front(); n_cmp++;
    if (32'(b_pred) !== e.val) begin n_bad++; $display("FAIL %s: actual %0h expected %0h", e.name, b_pred, e.val); end
    b_lv = 1'b1;
    // 11 -> 10,01,00,00,00 then taken 01,10
    for (int i = 0; i < 7; i++) begin
      b_uv = 1'b1; b_ut = taken[i];
      sb_q.push_back('{$sformatf("bim_step_%0d", i), 32'(exp_pred[i])});
      tick(); b_uv = 1'b0;
      e = sb_q.pop_front(); n_cmp++;
      if (32'(b_pred) !== e.val) begin n_bad++; $display("FAIL %s: actual %0h expected %0h", e.name, b_pred, e.val); end
    end
    sb_q.push_back('{"bim_stat_br", 32'd11});
    sb_q.push_back('{"bim_stat_mp", 32'd0});
    e = sb_q.pop_front(); n_cmp++;
    if (32'(b_sb) !== e.val) begin n_bad++; $display("FAIL %s: actual %0d expected %0d", e.name, b_sb, e.val); end
    e = sb_q.pop_front(); n_cmp++;
    if (32'(b_sm) !== e.val) begin n_bad++; $display("FAIL %s: actual %0d expected %0d", e.name, b_sm, e.val); end
  endtask

  task automatic test_target();
    exp_t        e;
    logic [31:0] pcs  [6];
    logic [31:0] offs [6];
    pcs[0] = 32'h0000_0100; offs[0] = 32'hFFFF_FFF8;
    pcs[1] = 32'hFFFF_FFFC; offs[1] = 32'h0000_0008;
    for (int i = 2; i < 6; i++) begin
      pcs[i] = $urandom; offs[i] = $urandom;
    end
    for (int i = 0; i < 6; i++) begin
      b_pc = pcs[i]; b_off = offs[i];
      #1;
      if (i == 0) sb_q.push_back('{"tgt_neg", 32'h0000_00F8});
      else if (i == 1) sb_q.push_back('{"tgt_wrap", 32'h0000_0004});
      else sb_q.push_back('{$sformatf("tgt_rand_%0d", i), pcs[i] + offs[i]});
      e = sb_q.pop_front(); n_cmp++;
      if (b_tgt !== e.val) begin n_bad++; $display("FAIL %s: actual %h expected %h", e.name, b_tgt, e.val); end
    end
    b_off = '0;
  endtask

  task automatic test_gshare();
    exp_t       e;
    logic       outc [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [3:0] ghr = 4'd0;
    g_lv = 1'b1; g_pc = 32'h40; g_uidx = 6'd0;
    for (int i = 0; i < 4; i++) begin
      g_uv = 1'b1; g_ut = outc[i];
      #1;
      // Lookup in the update cycle still sees the old history
      sb_q.push_back('{$sformatf("gsh_pre_idx_%0d", i), 32'(6'd16 ^ {2'b00, ghr})});
      e = sb_q.pop_front(); n_cmp++;
      if (32'(g_lidx) !== e.val) begin n_bad++; $display("FAIL %s: actual %0d expected %0d", e.name, g_lidx, e.val); end
      ghr = {ghr[2:0], outc[i]};
      tick(); g_uv = 1'b0;
    end
    sb_q.push_back('{"gsh_idx_29", 32'd29});
    e = sb_q.pop_front(); n_cmp++;
    if (32'(g_lidx) !== e.val) begin n_bad++; $display("FAIL %s: actual %0d expected %0d", e.name, g_lidx, e.val); end
    g_pc = 32'hFC;
    #1;
    sb_q.push_back('{"gsh_idx_50", 32'd50});
    sb_q.push_back('{"gsh_stats", 32'h0004_0000});
    sb_q.push_back('{"gsh_target", 32'h0000_00FC});
    e = sb_q.pop_front(); n_cmp++;
    if (32'(g_lidx) !== e.val) begin n_bad++; $display("FAIL %s: actual %0d expected %0d", e.name, g_lidx, e.val); end
    e = sb_q.pop_front(); n_cmp++;
    if ({g_sb, g_sm} !== e.val) begin n_bad++; $display("FAIL %s: actual %h expected %h", e.name, {g_sb, g_sm}, e.val); end
    e = sb_q.pop_front(); n_cmp++;
    if (g_tgt !== e.val) begin n_bad++; $display("FAIL %s: actual %h expected %h", e.name, g_tgt, e.val); end
  endtask

  task automatic test_collision();
    exp_t e;
    b_lv = 1'b1; b_pc = 32'h1C; b_uv = 1'b1; b_uidx = 6'd7; b_ut = 1'b1;
    #1;
    sb_q.push_back('{"coll_same_cycle", 32'd0});
    sb_q.push_back('{"coll_next_cycle", 32'd1});
    e = sb_q.pop_front(); n_cmp++;
    if (32'(b_pred) !== e.val) begin n_bad++; $display("FAIL %s: actual %0h expected %0h", e.name, b_pred, e.val); end
    tick(); b_uv = 1'b0;
    e = sb_q.pop_front(); n_cmp++;
    if (32'(b_pred) !== e.val) begin n_bad++; $display("FAIL %s: actual %0h expected %0h", e.name, b_pred, e.val); end
  endtask

  task automatic test_stats_reset();
    exp_t e;
    int   cnt;
    s_lv = 1'b1; s_pc = 32'h0; s_uidx = 6'd9; s_ut = 1'b1; s_um = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      s_uv = 1'b1;
      sb_q.push_back('{$sformatf("stat_sat_%0d", i), 32'(i > 3 ? 4'hF : {2'(i), 2'(i)})});
      tick(); s_uv = 1'b0;
      e = sb_q.pop_front(); n_cmp++;
      if (32'({s_sb, s_sm}) !== e.val) begin n_bad++; $display("FAIL %s: actual %h expected %h", e.name, {s_sb, s_sm}, e.val); end
    end
    // Invalid update with mispredict high changes nothing; GHR now 2'b11
    tick();
    sb_q.push_back('{"stat_idle", 32'hF});
    sb_q.push_back('{"stat_ghr_idx", 32'd3});
    e = sb_q.pop_front(); n_cmp++;
    if (32'({s_sb, s_sm}) !== e.val) begin n_bad++; $display("FAIL %s: actual %h expected %h", e.name, {s_sb, s_sm}, e.val); end
    e = sb_q.pop_front(); n_cmp++;
    if (32'(s_lidx) !== e.val) begin n_bad++; $display("FAIL %s: actual %0d expected %0d", e.name, s_lidx, e.val); end
    s_um = 1'b0;
    s_rst = 1'b1;
    tick();
    s_rst = 1'b0;
    sb_q.push_back('{"rst_ready_low", 32'd0});
    sb_q.push_back('{"rst_stats_clear", 32'd0});
    e = sb_q.pop_front(); n_cmp++;
    if (32'(s_rdy) !== e.val) begin n_bad++; $display("FAIL %s: actual %0h expected %0h", e.name, s_rdy, e.val); end
    e = sb_q.pop_front(); n_cmp++;
    if (32'({s_sb, s_sm}) !== e.val) begin n_bad++; $display("FAIL %s: actual %h expected %h", e.name, {s_sb, s_sm}, e.val); end
    cnt = 0;
    while (s_rdy !== 1'b1 && cnt < 200) begin
      cnt++;
      tick();
    end
    sb_q.push_back('{"rst_init_cycles", 32'd64});
    sb_q.push_back('{"rst_ghr_clear", 32'd0});
    sb_q.push_back('{"rst_target", 32'd0});
    e = sb_q.pop_front(); n_cmp++;
    if (32'(cnt) !== e.val) begin n_bad++; $display("FAIL %s: actual %0d expected %0d", e.name, cnt, e.val); end
    e = sb_q.pop_front(); n_cmp++;
    if (32'(s_lidx) !== e.val) begin n_bad++; $display("FAIL %s: actual %0d expected %0d", e.name, s_lidx, e.val); end
    e = sb_q.pop_front(); n_cmp++;
    if (s_tgt !== e.val) begin n_bad++; $display("FAIL %s: actual %h expected %h", e.name, s_tgt, e.val); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    b_rst = 1'b1; b_lv = 1'b0; b_pc = '0; b_off = '0; b_uv = 1'b0; b_uidx = '0; b_ut = 1'b0; b_um = 1'b0;
    g_rst = 1'b1; g_lv = 1'b0; g_pc = '0; g_off = '0; g_uv = 1'b0; g_uidx = '0; g_ut = 1'b0; g_um = 1'b0;
    s_rst = 1'b1; s_lv = 1'b0; s_pc = '0; s_off = '0; s_uv = 1'b0; s_uidx = '0; s_ut = 1'b0; s_um = 1'b0;
    test_reset();
    test_bimodal();
    test_target();
    test_gshare();
    test_collision();
    test_stats_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
